// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial bit-pattern detector. The pattern is PAT_W bits wide and can be
// reloaded at runtime. The detector provides:
//   - a combinational Mealy output,
//   - a registered Moore output,
//   - a saturating match counter.
// Overlapping or non-overlapping detection is selected per accepted sample.
// The first bit received is compared with the MSB of the pattern.
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous, active-low reset
//   en        : sample strobe; x is consumed only when en=1
//   x         : serial data bit
//   pat_in    : new pattern (MSB = first bit received)
//   pat_load  : latch pat_in; takes priority over en, and x is discarded
//   overlap   : 1 = overlapping detection, 0 = non-overlapping
//   clr_cnt   : clear the match counter (to 1 if a match occurs this cycle)
//   y_mealy   : combinational match; the current x completes the pattern
//   y_moore   : registered match flag for the last accepted sample
//   match_cnt : saturating count of matches
// -----------------------------------------------------------------------------
module seq_detect_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             x,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             pat_load,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             y_mealy,
   output logic             y_moore,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int               FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic              moore_q, moore_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [PAT_W-1:0]  cand;
   logic              match;

   // Only PAT_W-1 history bits are needed: the current x completes the window.
   // fill counts the valid history bits, so a match can only occur once
   // PAT_W-1 fresh samples precede x.
   assign cand  = {hist_q[PAT_W-2:0], x};
   assign match = en & ~pat_load & reset & (fill_q == FILL_MAX) & (cand == pat_q);

   assign y_mealy   = match;
   assign y_moore   = moore_q;
   assign match_cnt = cnt_q;

   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      moore_d = moore_q;
      cnt_d   = cnt_q;

      if (pat_load) begin
         pat_d   = pat_in;
         fill_d  = '0;
         hist_d  = '0;
         moore_d = 1'b0;
      end else if (en) begin
         hist_d = cand;
         // Non-overlapping mode discards the history after a match, so the
         // next match needs PAT_W fresh samples.
         if (match && !overlap) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end
         moore_d = match;
      end

      // If a clear coincides with a match, the match is still counted.
      if (clr_cnt) begin
         cnt_d = CNT_W'(match);
      end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= PAT_RST;
         moore_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         moore_q <= moore_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector with Mealy and Moore outputs. The pattern is runtime-loadable. Overlapping and non-overlapping detection are selectable. A saturating match counter is included. It generalises the fixed 4-bit "1101" Mealy/Moore detector pair into one block of any pattern width, and sits on single-bit serial streams in the same designs.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits; must be ≥ 2.
- PAT_RST, 4'b1101 (PAT_W bits), pattern loaded at reset.
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  sample strobe; x is consumed only on cycles with en=1.
- x  input  1  serial data bit.
- pat_in  input  PAT_W  new pattern; MSB is the first bit received, LSB the last.
- pat_load  input  1  latch pat_in into the pattern register.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clr_cnt  input  1  clear the match counter.
- y_mealy  output  1  combinational match; the current x completes the pattern.
- y_moore  output  1  registered match flag for the last accepted sample.
- match_cnt  output  CNT_W  saturating count of matches.

## Operation
- State: hist[PAT_W-1:0] shift register, fill counter (0..PAT_W-1, saturating), pat_q[PAT_W-1:0], y_moore flop, match_cnt.
- Reset (reset=0 at the edge): hist=0, fill=0, pat_q=PAT_RST, y_moore=0, match_cnt=0. y_mealy is forced to 0 while reset=0.
- Candidate cand = {hist[PAT_W-2:0], x}.
- match = en & ~pat_load & reset & (fill == PAT_W-1) & (cand == pat_q). y_mealy = match.
- Accepted sample (en=1, pat_load=0):
  - hist <= cand.
  - If match and overlap=0: fill <= 0. The next match therefore needs PAT_W fresh samples.
  - Otherwise fill <= min(fill+1, PAT_W-1).
  - y_moore <= match.
- en=0 with no load: hist, fill and y_moore hold. y_moore behaves as a Moore state, not a pulse.
- pat_load=1 has priority over en:
  - pat_q <= pat_in; fill <= 0; hist <= 0; y_moore <= 0.
  - The x on that cycle is discarded and y_mealy=0.
- The overlap input is sampled per accepted sample. Changing it mid-stream affects only matches completed from then on.
- Counter:
  - clr_cnt=1, no match: match_cnt <= 0.
  - clr_cnt=1 with match: match_cnt <= 1.
  - Match only: match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - Otherwise hold.
- Bit order: pattern 4'b1101 matches the serial sequence 1,1,0,1 (first bit is the MSB).

## Timing
- y_mealy: zero latency. It is combinational from x, en, pat_load and reset, and valid before the edge that accepts the final pattern bit.
- y_moore: rises on the edge that accepts the final bit, i.e. one cycle after y_mealy. It stays high until the next accepted sample, pat_load, or reset.
- match_cnt updates on the same edge as y_moore.
- A new pattern is active for the first sample accepted on the cycle after pat_load. The first match after a load needs PAT_W accepted samples.
- Overlap mode: a match is possible on every accepted sample once fill is saturated.
- Reset mid-stream: all state is cleared on that edge, partial history is lost, and pat_q returns to PAT_RST (not to the last loaded pattern).

## Test plan
- Reset defaults: hold reset=0 for 2 cycles with x=1, en=1 → y_mealy=0, y_moore=0, match_cnt=0; after release pat_q=1101.
- Default pattern, overlap=1, en=1, stream 0,0,1,1,0,1,1,1,0,1 → y_mealy high on samples 6 and 10, y_moore high on the cycles after them, match_cnt=2.
- Overlap vs non-overlap with stream 1,1,0,1,1,0,1:
  - overlap=1 → matches at samples 4 and 7, match_cnt=2.
  - overlap=0 → match at sample 4 only, match_cnt=1.
- en gaps: insert en=0 cycles with x toggling inside 1,1,0,1 → a single match, the ignored x values have no effect, and y_moore holds its value across the gaps.
- pat_load 4'b0000 after partial stream 1,1,0, then zeros with overlap=1 → no match on the load cycle; first y_mealy on the 4th accepted zero, then on every zero.
- CNT_W=2 with 5 overlapping matches → match_cnt saturates at 3. clr_cnt coincident with a match → match_cnt=1; clr_cnt alone → 0.
